// File: rtl/tap_ir_ctrl.sv
// JTAG TAP controller with a 4-bit instruction register.
// Follows the IEEE 1149.1 TMS state machine, scans the IR from TDI and exposes the latched instruction and DR strobes.
module tap_ir_ctrl #(
  parameter int unsigned         IR_WIDTH    = 4,
  parameter logic [IR_WIDTH-1:0] RESET_INSTR = 4'h7,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE  = 4'b0001
) (
  input  logic                TCK,
  input  logic                RST,
  input  logic                TMS,
  input  logic                TDI,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic                IR_TDO,
  output logic [3:0]          TAP_STATE,
  output logic                TEST_LOGIC_RESET,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic                SHIFT_IR,
  output logic                TDO_EN
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PA_DR  = 4'h3,
    EX2_DR = 4'h0,
    UP_DR  = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PA_IR  = 4'hB,
    EX2_IR = 4'h8,
    UP_IR  = 4'hD
  } tap_state_e;

  tap_state_e          r_state;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] r_latch_ir;

  // NOTE: every register here is assigned with <= so all updates on an edge
  // see the pre-edge state; blocking assignments would let the IR actions
  // below observe the already-advanced state.
  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      r_state    <= TLR;
      r_ir_shift <= '0;
      r_latch_ir <= RESET_INSTR;
    end else begin
      case (r_state)
        TLR:     r_state <= TMS ? TLR    : RTI;
        RTI:     r_state <= TMS ? SEL_DR : RTI;
        SEL_DR:  r_state <= TMS ? SEL_IR : CAP_DR;
        CAP_DR:  r_state <= TMS ? EX1_DR : SH_DR;
        SH_DR:   r_state <= TMS ? EX1_DR : SH_DR;
        EX1_DR:  r_state <= TMS ? UP_DR  : PA_DR;
        PA_DR:   r_state <= TMS ? EX2_DR : PA_DR;
        EX2_DR:  r_state <= TMS ? UP_DR  : SH_DR;
        UP_DR:   r_state <= TMS ? SEL_DR : RTI;
        SEL_IR:  r_state <= TMS ? TLR    : CAP_IR;
        CAP_IR:  r_state <= TMS ? EX1_IR : SH_IR;
        SH_IR:   r_state <= TMS ? EX1_IR : SH_IR;
        EX1_IR:  r_state <= TMS ? UP_IR  : PA_IR;
        PA_IR:   r_state <= TMS ? EX2_IR : PA_IR;
        EX2_IR:  r_state <= TMS ? UP_IR  : SH_IR;
        UP_IR:   r_state <= TMS ? SEL_DR : RTI;
        default: r_state <= TLR;
      endcase

      // The exit edge out of SH_IR still shifts, so W edges move W bits.
      if (r_state == CAP_IR) begin
        r_ir_shift <= IR_CAPTURE;
      end else if (r_state == SH_IR) begin
        r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
      end

      if (r_state == UP_IR) begin
        r_latch_ir <= r_ir_shift;
      end else if (r_state == TLR) begin
        r_latch_ir <= RESET_INSTR;
      end
    end
  end

  assign TAP_STATE        = r_state;
  assign LATCH_IR         = r_latch_ir;
  assign IR_TDO           = r_ir_shift[0];
  assign TEST_LOGIC_RESET = (r_state == TLR);
  assign CAPTURE_DR       = (r_state == CAP_DR);
  assign SHIFT_DR         = (r_state == SH_DR);
  assign UPDATE_DR        = (r_state == UP_DR);
  assign SHIFT_IR         = (r_state == SH_IR);
  assign TDO_EN           = SHIFT_DR | SHIFT_IR;

endmodule

// File: tb/tb_tap_ir_ctrl.sv
// Scoreboard bench for tap_ir_ctrl: a table-driven TAP model predicts every
// post-edge output; a negedge monitor compares the DUT against the queue.
module tb_tap_ir_ctrl;

  logic       TCK = 1'b0;
  logic       RST;
  logic       TMS;
  logic       TDI;
  logic [3:0] LATCH_IR;
  logic       IR_TDO;
  logic [3:0] TAP_STATE;
  logic       TEST_LOGIC_RESET, CAPTURE_DR, SHIFT_DR, UPDATE_DR, SHIFT_IR, TDO_EN;

  tap_ir_ctrl dut (
    .TCK              (TCK),
    .RST              (RST),
    .TMS              (TMS),
    .TDI              (TDI),
    .LATCH_IR         (LATCH_IR),
    .IR_TDO           (IR_TDO),
    .TAP_STATE        (TAP_STATE),
    .TEST_LOGIC_RESET (TEST_LOGIC_RESET),
    .CAPTURE_DR       (CAPTURE_DR),
    .SHIFT_DR         (SHIFT_DR),
    .UPDATE_DR        (UPDATE_DR),
    .SHIFT_IR         (SHIFT_IR),
    .TDO_EN           (TDO_EN)
  );

  always #5 TCK = ~TCK;

  localparam int S_TLR = 15, S_RTI = 12, S_SDR = 7, S_CDR = 6, S_SHDR = 2, S_E1DR = 1,
                 S_PDR = 3, S_E2DR = 0, S_UDR = 5, S_SIR = 4, S_CIR = 14, S_SHIR = 10,
                 S_E1IR = 9, S_PIR = 11, S_E2IR = 8, S_UIR = 13;
  localparam int RESET_INSTR = 7;
  localparam int IR_CAPTURE  = 1;

  typedef struct {
    int state;
    int latch;
    int tdo;
    int strobes;  // {tlr, cap_dr, sh_dr, up_dr, sh_ir, tdo_en}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int nxt0[16];
  int nxt1[16];
  int m_state;
  int m_ir;
  int m_latch;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic set_next(input int s, input int on0, input int on1);
    nxt0[s] = on0;
    nxt1[s] = on1;
  endtask

  task automatic init_table();
    set_next(S_TLR,  S_RTI,  S_TLR);
    set_next(S_RTI,  S_RTI,  S_SDR);
    set_next(S_SDR,  S_CDR,  S_SIR);
    set_next(S_SIR,  S_CIR,  S_TLR);
    set_next(S_CDR,  S_SHDR, S_E1DR);
    set_next(S_SHDR, S_SHDR, S_E1DR);
    set_next(S_E1DR, S_PDR,  S_UDR);
    set_next(S_PDR,  S_PDR,  S_E2DR);
    set_next(S_E2DR, S_SHDR, S_UDR);
    set_next(S_UDR,  S_RTI,  S_SDR);
    set_next(S_CIR,  S_SHIR, S_E1IR);
    set_next(S_SHIR, S_SHIR, S_E1IR);
    set_next(S_E1IR, S_PIR,  S_UIR);
    set_next(S_PIR,  S_PIR,  S_E2IR);
    set_next(S_E2IR, S_SHIR, S_UIR);
    set_next(S_UIR,  S_RTI,  S_SDR);
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    int   tlr, cdr, shdr, udr, shir;
    tlr  = (m_state == S_TLR)  ? 1 : 0;
    cdr  = (m_state == S_CDR)  ? 1 : 0;
    shdr = (m_state == S_SHDR) ? 1 : 0;
    udr  = (m_state == S_UDR)  ? 1 : 0;
    shir = (m_state == S_SHIR) ? 1 : 0;
    e.state   = m_state;
    e.latch   = m_latch;
    e.tdo     = m_ir % 2;
    e.strobes = tlr * 32 + cdr * 16 + shdr * 8 + udr * 4 + shir * 2 + ((shdr + shir) > 0 ? 1 : 0);
    return e;
  endfunction

  task automatic model_reset();
    m_state = S_TLR;
    m_ir    = 0;
    m_latch = RESET_INSTR;
    sb.push_back(model_outputs());
  endtask

  task automatic model_edge(input int tms, input int tdi);
    if (m_state == S_UIR) m_latch = m_ir;
    else if (m_state == S_TLR) m_latch = RESET_INSTR;
    if (m_state == S_CIR) m_ir = IR_CAPTURE;
    else if (m_state == S_SHIR) m_ir = m_ir / 2 + tdi * 8;
    m_state = (tms != 0) ? nxt1[m_state] : nxt0[m_state];
    sb.push_back(model_outputs());
  endtask

  // Inputs change just after a rising edge; the model predicts the next edge.
  task automatic step(input int tms, input int tdi);
    TMS = tms[0];
    TDI = tdi[0];
    @(posedge TCK);
    model_edge(tms, tdi);
    #1;
  endtask

  task automatic tms_seq(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) step(int'(pat[i]), 0);
  endtask

  // Assert between edges, hold across one negedge check, release away from posedge.
  task automatic pulse_reset();
    @(negedge TCK);
    #1;
    RST = 1'b1;
    model_reset();
    @(negedge TCK);
    #1;
    RST = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge TCK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tap_state", int'(TAP_STATE), e.state);
        check("latch_ir",  int'(LATCH_IR),  e.latch);
        check("ir_tdo",    int'(IR_TDO),    e.tdo);
        check("strobes", int'({TEST_LOGIC_RESET, CAPTURE_DR, SHIFT_DR, UPDATE_DR, SHIFT_IR, TDO_EN}),
              e.strobes);
      end
    end
  end

  initial begin : stimulus
    int steps;
    init_table();
    TMS = 1'b1;
    TDI = 1'b0;
    RST = 1'b1;
    #1;
    model_reset();
    @(negedge TCK);
    #1;
    RST = 1'b0;

    // Reset out of SH_IR with a nonzero shift stage, then leave TLR with TMS=0.
    tms_seq(16'b0_0110, 5);
    step(0, 1);
    step(0, 1);
    pulse_reset();
    step(0, 0);

    // IR load of 4'h1 from RTI.
    tms_seq(16'b0011, 4);
    step(0, 1);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    step(1, 0);
    step(0, 0);

    // Paused IR load of 4'hF.
    tms_seq(16'b0011, 4);
    step(0, 1);
    step(1, 1);
    step(0, 0);
    tms_seq(16'b000, 3);
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(1, 1);
    step(1, 0);
    step(0, 0);

    // DR scan must leave the instruction alone.
    tms_seq(16'b0110_0001, 8);

    // Leave SH_IR through EX1, PA, EX2, UP without further shifting.
    tms_seq(16'b0011, 4);
    step(1, 1);
    tms_seq(16'b0110, 4);

    // From every state, five TMS=1 edges reach TLR, a sixth reloads the IR.
    for (int target = 0; target < 16; target++) begin
      pulse_reset();
      steps = 0;
      while (m_state != target && steps < 400) begin
        step($urandom_range(0, 1), $urandom_range(0, 1));
        steps++;
      end
      if (m_state != target) begin
        n_errors++;
        $display("FAIL steer: could not reach state 0x%0h", target);
      end
      for (int k = 0; k < 6; k++) step(1, $urandom_range(0, 1));
    end

    // Random walk with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else step(($urandom_range(0, 99) < 40) ? 1 : 0, $urandom_range(0, 1));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge TCK);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
